// File: rtl/mgmt_uart_pkg.sv
// mgmt_uart_pkg: FSM encodings and frame constants shared by the mgmt_uart slice
package mgmt_uart_pkg;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
   localparam int UART_FRAME_BITS = 10;
endpackage

// File: rtl/mgmt_uart_if.sv
// mgmt_uart_if: byte-level strobes between mgmt_uart and the management controller
interface mgmt_uart_if;
   logic [7:0] rx_data;
   logic       rx_en;
   logic       rx_frame_err;
   logic [7:0] tx_data;
   logic       tx_en;
   logic       tx_busy;
   logic       tx_done;
   modport master (input rx_data, rx_en, rx_frame_err, tx_busy, tx_done, output tx_data, tx_en);
   modport slave  (output rx_data, rx_en, rx_frame_err, tx_busy, tx_done, input tx_data, tx_en);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: down-counting bit timer; expire is high while the count sits at zero
module uart_bit_timer #(
   parameter int CLK_DIV = 1085
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic load_half,
   output logic expire
);
   logic [15:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= load ? 16'(CLK_DIV - 1) : load_half ? 16'(CLK_DIV / 2 - 1) : (r_cnt != '0) ? r_cnt - 16'd1 : r_cnt;
   assign expire = (r_cnt == '0);
endmodule

// File: rtl/mgmt_uart.sv
// mgmt_uart: full-duplex 8N1 UART between the management MCU pins and the controller
module mgmt_uart #(
   parameter int CLK_DIV = 1085
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  uart_rxd,
   output logic  uart_txd,
   mgmt_uart_if.slave bus
);
   import mgmt_uart_pkg::*;
   logic       r_rx_meta, r_rxs;
   rx_state_t  r_rx_st;
   logic [3:0] r_rx_bits;
   logic [7:0] r_rx_shift, r_rx_data;
   logic       r_rx_en, r_rx_ferr;
   logic       w_rx_exp, w_rx_load, w_rx_load_half;
   tx_state_t  r_tx_st;
   logic [9:0] r_tx_shift;
   logic [3:0] r_tx_bits;
   logic       w_tx_exp, w_tx_last, w_tx_acc, w_tx_load;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {r_rxs, r_rx_meta} <= 2'b11;
      else {r_rxs, r_rx_meta} <= {r_rx_meta, uart_rxd};
   assign w_rx_load_half = (r_rx_st == RX_IDLE) && !r_rxs;
   assign w_rx_load      = ((r_rx_st == RX_START) || (r_rx_st == RX_DATA)) && w_rx_exp;
   uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
      .clk(clk), .rst_n(rst_n), .load(w_rx_load), .load_half(w_rx_load_half), .expire(w_rx_exp)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rx_st    <= RX_IDLE;
         r_rx_bits  <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_en    <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_en   <= 1'b0;
         r_rx_ferr <= 1'b0;
         case (r_rx_st)
            RX_IDLE:  if (!r_rxs) r_rx_st <= RX_START;
            RX_START: if (w_rx_exp) begin
               r_rx_st   <= r_rxs ? RX_IDLE : RX_DATA;
               r_rx_bits <= '0;
            end
            RX_DATA:  if (w_rx_exp) begin
               r_rx_shift <= {r_rxs, r_rx_shift[7:1]};
               r_rx_bits  <= r_rx_bits + 4'd1;
               if (r_rx_bits == 4'd7) r_rx_st <= RX_STOP;
            end
            RX_STOP:  if (w_rx_exp) begin
               r_rx_st   <= r_rxs ? RX_IDLE : RX_BREAK;
               r_rx_en   <= r_rxs;
               r_rx_ferr <= !r_rxs;
               if (r_rxs) r_rx_data <= r_rx_shift;
            end
            RX_BREAK: if (r_rxs) r_rx_st <= RX_IDLE;
            default:  r_rx_st <= RX_IDLE;
         endcase
      end
   // The last stop-bit cycle doubles as an accept slot so frames can run back to back.
   assign w_tx_last = (r_tx_st == TX_SHIFT) && w_tx_exp && (r_tx_bits == 4'(UART_FRAME_BITS - 1));
   assign w_tx_acc  = bus.tx_en && ((r_tx_st == TX_IDLE) || w_tx_last);
   assign w_tx_load = w_tx_acc || ((r_tx_st == TX_SHIFT) && w_tx_exp);
   uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
      .clk(clk), .rst_n(rst_n), .load(w_tx_load), .load_half(1'b0), .expire(w_tx_exp)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_tx_st    <= TX_IDLE;
         r_tx_shift <= '1;
         r_tx_bits  <= '0;
      end else if (w_tx_acc) begin
         r_tx_st    <= TX_SHIFT;
         r_tx_shift <= {1'b1, bus.tx_data, 1'b0};
         r_tx_bits  <= '0;
      end else if (w_tx_last) begin
         r_tx_st <= TX_IDLE;
      end else if ((r_tx_st == TX_SHIFT) && w_tx_exp) begin
         r_tx_shift <= {1'b1, r_tx_shift[9:1]};
         r_tx_bits  <= r_tx_bits + 4'd1;
      end
   assign uart_txd         = r_tx_shift[0];
   assign bus.tx_busy      = (r_tx_st == TX_SHIFT) && !w_tx_last;
   assign bus.tx_done      = w_tx_last;
   assign bus.rx_data      = r_rx_data;
   assign bus.rx_en        = r_rx_en;
   assign bus.rx_frame_err = r_rx_ferr;
endmodule

// File: tb/tb_mgmt_uart.sv
// tb_mgmt_uart: scoreboard bench for mgmt_uart at 16 clocks per bit
module tb_mgmt_uart;
   localparam int N   = 16;
   localparam int BIT = N * 100;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic rxd = 1'b1;
   logic txd;
   mgmt_uart_if bus();
   mgmt_uart #(.CLK_DIV(N)) dut (.clk(clk), .rst_n(rst_n), .uart_rxd(rxd), .uart_txd(txd), .bus(bus));
   always #50 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int tests = 0, fails = 0;
   typedef struct {bit err; logic [7:0] data; int at;} rx_exp_t;
   typedef struct {logic [7:0] data; int at;} tx_exp_t;
   rx_exp_t rx_q[$];
   tx_exp_t tx_q[$];
   int      done_q[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (bus.rx_en || bus.rx_frame_err) begin
         if (rx_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: got en=%0b err=%0b data=%0h, want no strobe", bus.rx_en, bus.rx_frame_err, bus.rx_data);
         end else begin
            rx_exp_t e;
            e = rx_q.pop_front();
            chk("rx_kind", {bus.rx_en, bus.rx_frame_err}, e.err ? 2'b01 : 2'b10);
            chk("rx_data", bus.rx_data, e.data);
            if (e.at >= 0) chk("rx_latency", cyc, e.at);
         end
      end
      if (bus.tx_done) begin
         if (done_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_done_unexpected: got tx_done=1 at cycle %0d, want none", cyc);
         end else begin
            chk("tx_done_cycle", cyc, done_q.pop_front());
            chk("tx_busy_on_done", bus.tx_busy, 1'b0);
         end
      end
   end
   initial begin : tx_mon
      int st;
      logic [9:0] w0, w1;
      bit ab, busy_ok;
      tx_exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && txd == 1'b0) begin
            st = cyc; ab = 0; busy_ok = 1; w0 = '0; w1 = '0;
            for (int k = 0; k < 10 * N; k++) begin
               if (k > 0) @(negedge clk);
               if (!rst_n) begin ab = 1; break; end
               if (k % N == 0) w0[k / N] = txd;
               if (k % N == N - 1) w1[k / N] = txd;
               if (k < 10 * N - 1 && !bus.tx_busy) busy_ok = 0;
            end
            if (!ab) begin
               if (tx_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL tx_unexpected: got frame %0h at cycle %0d, want none", w0, st);
               end else begin
                  e = tx_q.pop_front();
                  chk("tx_frame_first", w0, {1'b1, e.data, 1'b0});
                  chk("tx_frame_last", w1, {1'b1, e.data, 1'b0});
                  chk("tx_start_cycle", st, e.at);
                  chk("tx_busy_in_frame", busy_ok, 1'b1);
               end
            end
         end
      end
   end
   task automatic send_rx(input logic [7:0] b, input int bt, input logic stop, input int hold);
      rxd = 1'b0;
      #bt;
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         #bt;
      end
      rxd = stop;
      #(bt + hold);
      rxd = 1'b1;
   endtask
   task automatic send_tx(input logic [7:0] d);
      bus.tx_data = d;
      bus.tx_en   = 1'b1;
      @(negedge clk);
      bus.tx_en   = 1'b0;
   endtask
   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = bus.tx_done;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL tx_done_timeout: got no tx_done in 300 cycles, want one");
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_txd"}, txd, 1'b1);
      chk({tag, "_rx_en"}, bus.rx_en, 1'b0);
      chk({tag, "_rx_ferr"}, bus.rx_frame_err, 1'b0);
      chk({tag, "_tx_done"}, bus.tx_done, 1'b0);
      chk({tag, "_tx_busy"}, bus.tx_busy, 1'b0);
      chk({tag, "_rx_data"}, bus.rx_data, 8'h00);
   endtask
   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation still running, want finish");
      $fatal(1);
   end
   initial begin
      int c;
      bus.tx_en = 1'b0;
      bus.tx_data = 8'h00;
      #1 rst_n = 1'b0;
      #1 chk_reset("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      c = cyc;
      rx_q.push_back('{0, 8'hA5, c + 155});
      send_rx(8'hA5, BIT, 1'b1, 0);
      repeat (40) @(negedge clk);
      rx_q.push_back('{0, 8'h3C, -1});
      send_rx(8'h3C, BIT * 96 / 100, 1'b1, 0);
      repeat (40) @(negedge clk);
      rx_q.push_back('{0, 8'h3C, -1});
      send_rx(8'h3C, BIT * 104 / 100, 1'b1, 0);
      repeat (40) @(negedge clk);
      rxd = 1'b0;
      repeat (6) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      rx_q.push_back('{1, 8'h3C, -1});
      send_rx(8'hFF, BIT, 1'b0, 100 * 100);
      repeat (40) @(negedge clk);
      rx_q.push_back('{0, 8'h12, -1});
      send_rx(8'h12, BIT, 1'b1, 0);
      repeat (40) @(negedge clk);
      c = cyc;
      tx_q.push_back('{8'h55, c + 1});
      done_q.push_back(c + 160);
      send_tx(8'h55);
      wait_done();
      repeat (20) @(negedge clk);
      fork
         begin
            c = cyc;
            tx_q.push_back('{8'h81, c + 1});
            tx_q.push_back('{8'h0F, c + 161});
            done_q.push_back(c + 160);
            done_q.push_back(c + 320);
            send_tx(8'h81);
            repeat (49) @(negedge clk);
            send_tx(8'hAA);
            wait_done();
            send_tx(8'h0F);
            wait_done();
         end
         begin
            repeat (30) @(negedge clk);
            rx_q.push_back('{0, 8'h5A, -1});
            send_rx(8'h5A, BIT, 1'b1, 0);
         end
      join
      repeat (20) @(negedge clk);
      send_tx(8'h00);
      rxd = 1'b0;
      repeat (60) @(negedge clk);
      #20 rst_n = 1'b0;
      #10 chk_reset("midreset");
      rxd = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      fork
         begin
            rx_q.push_back('{0, 8'h02, -1});
            send_rx(8'h02, BIT, 1'b1, 0);
         end
         begin
            c = cyc;
            tx_q.push_back('{8'h02, c + 1});
            done_q.push_back(c + 160);
            send_tx(8'h02);
         end
      join
      repeat (200) @(negedge clk);
      chk("rx_q_drained", rx_q.size(), 0);
      chk("tx_q_drained", tx_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
